// File: rtl/uarch_rst_sequencer_pkg.sv
// Shared types and helpers for the fence.t microarchitectural-reset sequencer.
package uarch_rst_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    DRAIN,
    RST,
    INIT
  } fence_t_seq_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/uarch_rst_sequencer_counter.sv
// Generic loadable up/down counter; load has priority over counting.
module uarch_rst_sequencer_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else if (load_i) begin
      q_o <= d_i;
    end else if (en_i) begin
      q_o <= down_i ? q_o - WIDTH'(1) : q_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uarch_rst_sequencer.sv
// fence.t sequencer: flush domains in order, drain, pulse uarch reset, hold cache-init suppression.
module uarch_rst_sequencer
  import uarch_rst_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned INIT_CYCLES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic [31:0]            pad_i,
  input  logic                   time_irq_i,
  output logic [NUM_DOMAINS-1:0] flush_o,
  input  logic [NUM_DOMAINS-1:0] flush_ack_i,
  input  logic                   busy_i,
  output logic                   rst_uarch_no,
  output logic                   cache_init_no,
  output logic                   halt_o,
  output logic [31:0]            ceil_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam int unsigned CNT_W = $clog2(max3(TIMEOUT_CYCLES, RST_CYCLES, INIT_CYCLES) + 1);

  fence_t_seq_state_e state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               err_d;
  logic               done_d;
  logic [31:0]        ceil_d;
  logic               irq_q;
  logic [31:0]        pad_cnt;
  logic               dom_ack;
  logic               dom_last;
  logic               dom_tmo;

  // Pad window: reload on the timer irq rising edge, otherwise count down to zero.
  uarch_rst_sequencer_counter #(
    .WIDTH(32)
  ) i_pad_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (pad_cnt != '0),
    .load_i (time_irq_i & ~irq_q),
    .down_i (1'b1),
    .d_i    (pad_i),
    .q_o    (pad_cnt)
  );

  assign dom_ack  = flush_ack_i[idx_q];
  assign dom_last = (idx_q == IDX_W'(NUM_DOMAINS - 1));
  assign dom_tmo  = (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign halt_o   = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cyc_d         = '0;
    err_d         = err_o;
    ceil_d        = ceil_o;
    done_d        = 1'b0;
    flush_o       = '0;
    rst_uarch_no  = 1'b1;
    cache_init_no = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = FLUSH;
          idx_d   = '0;
          err_d   = 1'b0;
        end
      end
      FLUSH: begin
        flush_o[idx_q] = 1'b1;
        cyc_d          = cyc_q + CNT_W'(1);
        // A timeout advances exactly like an ack; only a missing ack flags the error.
        if (dom_ack || dom_tmo) begin
          cyc_d = '0;
          if (!dom_ack) begin
            err_d = 1'b1;
          end
          if (dom_last) begin
            state_d = DRAIN;
            ceil_d  = (pad_cnt == '0) ? '0 : pad_i - pad_cnt;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (!busy_i && (pad_cnt == '0)) begin
          state_d = RST;
        end
      end
      RST: begin
        rst_uarch_no = 1'b0;
        cyc_d        = cyc_q + CNT_W'(1);
        if (cyc_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = INIT;
          cyc_d   = '0;
        end
      end
      INIT: begin
        cache_init_no = 1'b1;
        cyc_d         = cyc_q + CNT_W'(1);
        if (cyc_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d = IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      err_o   <= 1'b0;
      done_o  <= 1'b0;
      ceil_o  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      err_o   <= err_d;
      done_o  <= done_d;
      ceil_o  <= ceil_d;
      irq_q   <= time_irq_i;
    end
  end

endmodule
